// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_e;

  // Enable/flush bundle driven to the PC and the inter-stage registers.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
  } pipe_ctrl_t;

  function automatic logic src_match(input logic used,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
    return used & (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory wait,
// divider wait and taken-branch redirect, plus saturating perf counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rj,
  input  logic [REG_ADDR_W-1:0] id_rk,
  input  logic                  id_rj_used,
  input  logic                  id_rk_used,
  input  logic                  ex_is_load,
  input  logic                  ex_rf_we,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_div,
  input  logic                  div_done,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_en,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned TMR_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TMO_M1 = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          TMO_EN = (MEM_TIMEOUT != 0);

  state_e     state_q;
  state_e     state_d;
  pipe_ctrl_t ctrl;

  logic mem_stall;
  logic div_stall;
  logic load_use;
  logic br_flush;

  logic             mem_timeout_q;
  logic             mem_timeout_d;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_hit;
  logic [TMR_W-1:0] tmr_q;

  // Hazard detection in priority order: mem > div > branch > load-use.
  always_comb begin
    mem_stall = mem_req & ~mem_ack;
    div_stall = ex_is_div & ~div_done & ~mem_stall;
    br_flush  = br_taken & ~mem_stall & ~div_stall;
    load_use  = ex_is_load & ex_rf_we & (ex_rd != REG_ZERO)
              & (src_match(id_rj_used, id_rj, ex_rd) | src_match(id_rk_used, id_rk, ex_rd))
              & ~mem_stall & ~div_stall & ~br_taken;
  end

  // Next state and the combinational enable/flush bundle.
  always_comb begin
    state_d           = ST_RUN;
    ctrl.pc_en        = 1'b1;
    ctrl.if_id_en     = 1'b1;
    ctrl.if_id_flush  = 1'b0;
    ctrl.id_ex_en     = 1'b1;
    ctrl.id_ex_flush  = 1'b0;
    ctrl.ex_mem_en    = 1'b1;
    ctrl.ex_mem_flush = 1'b0;
    ctrl.mem_wb_en    = 1'b1;

    if (rst) begin
      ctrl.pc_en        = 1'b0;
      ctrl.if_id_en     = 1'b0;
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_en     = 1'b0;
      ctrl.id_ex_flush  = 1'b1;
      ctrl.ex_mem_en    = 1'b0;
      ctrl.ex_mem_flush = 1'b1;
      ctrl.mem_wb_en    = 1'b0;
    end else if (mem_stall) begin
      state_d        = ST_MEM_WAIT;
      ctrl.pc_en     = 1'b0;
      ctrl.if_id_en  = 1'b0;
      ctrl.id_ex_en  = 1'b0;
      ctrl.ex_mem_en = 1'b0;
      ctrl.mem_wb_en = 1'b0;
    end else if (div_stall) begin
      // EX holds the divide; a bubble drains into MEM behind it.
      state_d           = ST_DIV_WAIT;
      ctrl.pc_en        = 1'b0;
      ctrl.if_id_en     = 1'b0;
      ctrl.id_ex_en     = 1'b0;
      ctrl.ex_mem_flush = 1'b1;
    end else if (br_flush) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en       = 1'b0;
      ctrl.if_id_en    = 1'b0;
      ctrl.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Wait timer counts cycles spent in MEM_WAIT; timeout is sticky until reset.
  always_comb begin
    tmr_inc       = (state_q == ST_MEM_WAIT);
    tmr_clr       = rst | (state_d != ST_MEM_WAIT);
    tmr_hit       = TMO_EN & tmr_inc & ~tmr_clr & (tmr_q == TMR_W'(TMO_M1));
    mem_timeout_d = mem_timeout_q | tmr_hit;
  end

  sat_counter #(.W(TMR_W)) u_wait_tmr (
    .clk (clk),
    .clr (tmr_clr),
    .inc (tmr_inc),
    .q   (tmr_q)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (~ctrl.pc_en),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .inc (br_flush & ~rst),
    .q   (flush_count)
  );

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;
  import cpu_pkg::*;

  localparam int unsigned CNT_W = 32;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en}
  localparam logic [7:0] C_RUN  = 8'b1101_0101;
  localparam logic [7:0] C_RST  = 8'b0010_1010;
  localparam logic [7:0] C_MEM  = 8'b0000_0000;
  localparam logic [7:0] C_DIV  = 8'b0000_0111;
  localparam logic [7:0] C_BR   = 8'b1111_1101;
  localparam logic [7:0] C_LU   = 8'b0001_1101;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rj, id_rk, ex_rd;
  logic id_rj_used, id_rk_used, ex_is_load, ex_rf_we, ex_is_div, div_done;
  logic mem_req, mem_ack, br_taken;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_en, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [7:0] ctl;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rj        (id_rj),
    .id_rk        (id_rk),
    .id_rj_used   (id_rj_used),
    .id_rk_used   (id_rk_used),
    .ex_is_load   (ex_is_load),
    .ex_rf_we     (ex_rf_we),
    .ex_rd        (ex_rd),
    .ex_is_div    (ex_is_div),
    .div_done     (div_done),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .br_taken     (br_taken),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_en    (mem_wb_en),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic idle_inputs();
    id_rj = 5'd0; id_rk = 5'd0; ex_rd = 5'd0;
    id_rj_used = 1'b0; id_rk_used = 1'b0;
    ex_is_load = 1'b0; ex_rf_we = 1'b0;
    ex_is_div = 1'b0; div_done = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
  endtask

  // Advance one clock; inputs are driven 1ns after the edge, outputs read 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    #1;
    n_checks++;
    if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST); end
    n_checks++;
    if (stall_cycles !== 0 || flush_count !== 0) begin
      n_fail++; $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0 0", stall_cycles, flush_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL idle_ctl: got %b expected %b", ctl, C_RUN); end
    tick(); tick();
    n_checks++;
    if (stall_cycles !== 0 || flush_count !== 0 || mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL idle_cnt: got stall=%0d flush=%0d tmo=%b expected 0 0 0", stall_cycles, flush_count, mem_timeout);
    end
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rd = 5'd5; id_rj = 5'd5; id_rj_used = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rj_ctl: got %b expected %b", ctl, C_LU); end
    tick();
    exp_stall++;
    idle_inputs();
    n_checks++;
    if (stall_cycles !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL lu_rj_stall: got %0d expected %0d", stall_cycles, exp_stall); end

    // Destination r0 is never a hazard.
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rd = 5'd0; id_rj = 5'd0; id_rj_used = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_r0_ctl: got %b expected %b", ctl, C_RUN); end
    tick();

    ex_rd = 5'd7; id_rj = 5'd3; id_rk = 5'd7; id_rk_used = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rk_ctl: got %b expected %b", ctl, C_LU); end
    id_rk_used = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL lu_rk_unused_ctl: got %b expected %b", ctl, C_RUN); end
    id_rk_used = 1'b1;
    tick();
    exp_stall++;

    // Load-use together with a taken branch resolves as a branch.
    br_taken = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_BR) begin n_fail++; $display("FAIL lu_br_ctl: got %b expected %b", ctl, C_BR); end
    tick();
    exp_flush++;
    idle_inputs();
    n_checks++;
    if (stall_cycles !== CNT_W'(exp_stall) || flush_count !== CNT_W'(exp_flush)) begin
      n_fail++; $display("FAIL lu_br_cnt: got stall=%0d flush=%0d expected %0d %0d", stall_cycles, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic test_mem_wait();
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_MEM) begin n_fail++; $display("FAIL mem_stall_ctl[%0d]: got %b expected %b", i, ctl, C_MEM); end
      if (i > 0) begin
        n_checks++;
        if (dut.state_q !== ST_MEM_WAIT) begin n_fail++; $display("FAIL mem_state[%0d]: got %0d expected %0d", i, dut.state_q, ST_MEM_WAIT); end
      end
      tick();
    end
    exp_stall += 3;
    mem_ack = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL mem_ack_ctl: got %b expected %b", ctl, C_RUN); end
    tick();
    idle_inputs();
    n_checks++;
    if (dut.state_q !== ST_RUN) begin n_fail++; $display("FAIL mem_release_state: got %0d expected %0d", dut.state_q, ST_RUN); end
    n_checks++;
    if (stall_cycles !== CNT_W'(exp_stall) || mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mem_cnt: got stall=%0d tmo=%b expected %0d 0", stall_cycles, mem_timeout, exp_stall);
    end
  endtask

  task automatic test_div_branch();
    ex_is_div = 1'b1; div_done = 1'b0; br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_DIV) begin n_fail++; $display("FAIL div_ctl[%0d]: got %b expected %b", i, ctl, C_DIV); end
      tick();
    end
    exp_stall += 4;
    div_done = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_BR) begin n_fail++; $display("FAIL div_done_ctl: got %b expected %b", ctl, C_BR); end
    tick();
    exp_flush++;
    idle_inputs();
    n_checks++;
    if (stall_cycles !== CNT_W'(exp_stall) || flush_count !== CNT_W'(exp_flush)) begin
      n_fail++; $display("FAIL div_cnt: got stall=%0d flush=%0d expected %0d %0d", stall_cycles, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (mem_timeout !== (i >= 5)) begin n_fail++; $display("FAIL tmo_edge[%0d]: got %b expected %b", i, mem_timeout, (i >= 5)); end
    end
    exp_stall += 6;
    mem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (mem_timeout !== 1'b1 || stall_cycles !== CNT_W'(exp_stall)) begin
      n_fail++; $display("FAIL tmo_sticky: got tmo=%b stall=%0d expected 1 %0d", mem_timeout, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1'b1; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RST) begin n_fail++; $display("FAIL rst_wait_ctl: got %b expected %b", ctl, C_RST); end
    tick();
    n_checks++;
    if (dut.state_q !== ST_RUN) begin n_fail++; $display("FAIL rst_wait_state: got %0d expected %0d", dut.state_q, ST_RUN); end
    n_checks++;
    if (stall_cycles !== 0 || flush_count !== 0 || mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_cnt: got stall=%0d flush=%0d tmo=%b expected 0 0 0", stall_cycles, flush_count, mem_timeout);
    end
    tick();
    n_checks++;
    if (ctl !== C_RST) begin n_fail++; $display("FAIL rst_hold_ctl: got %b expected %b", ctl, C_RST); end
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (ctl !== C_RUN) begin n_fail++; $display("FAIL rst_release_ctl: got %b expected %b", ctl, C_RUN); end
    tick();
    n_checks++;
    if (stall_cycles !== 0) begin n_fail++; $display("FAIL rst_release_stall: got %0d expected 0", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_div_branch();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
